// File: rtl/counter_ctrl_sched.sv
// counter_ctrl_sched
//   Owns the board count register. Debounced button pulses (up, down, clear,
//   mode) are latched into sticky pending bits and served one per clock by
//   fixed priority: clear > mode > up > down. An auto-run mode steps the count
//   from an internal prescaler tick every TICK_DIV clocks.
//
// Ports
//   global_clock  in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   btn_up        in   one-cycle debounced pulse
//   btn_down      in   one-cycle debounced pulse
//   btn_clear     in   one-cycle debounced pulse
//   btn_mode      in   one-cycle debounced pulse
//   count_value   out  [WIDTH-1:0] current count (0..MAX_COUNT), registered
//   mode_state    out  [1:0] 00 MANUAL, 01 AUTO_RUN, 10 AUTO_PAUSE
//   count_dir     out  1 = up, 0 = down
//   step_pulse    out  one cycle high after each up/down step (not on clear)
//   wrap_pulse    out  one cycle high when that step wrapped
//   busy          out  high while any pending bit is set
module counter_ctrl_sched #(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 9999,
  parameter int TICK_DIV  = 100000000
) (
  input  logic             global_clock,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clear,
  input  logic             btn_mode,
  output logic [WIDTH-1:0] count_value,
  output logic [1:0]       mode_state,
  output logic             count_dir,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {
    MANUAL     = 2'b00,
    AUTO_RUN   = 2'b01,
    AUTO_PAUSE = 2'b10
  } mode_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);

  // Pending / served bit order: [3] clear, [2] mode, [1] up, [0] down
  logic [3:0]       pending_reg;
  logic [3:0]       served;
  logic [WIDTH-1:0] count_reg;
  logic [PW-1:0]    presc_reg;
  mode_t            mode_reg;
  logic             dir_reg;
  logic             step_pulse_reg;
  logic             wrap_pulse_reg;

  logic             tick;
  logic             do_step;
  logic             step_up;
  logic             wrap_hit;
  logic [WIDTH-1:0] step_value;

  // Fixed-priority pick of a single pending bit
  always_comb begin
    served = 4'b0000;
    if (pending_reg[3])      served = 4'b1000;
    else if (pending_reg[2]) served = 4'b0100;
    else if (pending_reg[1]) served = 4'b0010;
    else if (pending_reg[0]) served = 4'b0001;
  end

  // Tick is decided from the state before the edge, so a mode change leaving
  // AUTO_RUN on this edge still lets the tick step the count.
  assign tick = (mode_reg == AUTO_RUN) && (presc_reg == TICK_LAST);

  // Step decision. Clear wins over everything, including a coincident tick.
  // Ticks only happen in AUTO_RUN and manual steps only in MANUAL, so the two
  // never compete for the same edge.
  always_comb begin
    do_step = 1'b0;
    step_up = 1'b1;
    if (!served[3]) begin
      if (tick) begin
        do_step = 1'b1;
        step_up = dir_reg;
      end else if (mode_reg == MANUAL && served[1]) begin
        do_step = 1'b1;
        step_up = 1'b1;
      end else if (mode_reg == MANUAL && served[0]) begin
        do_step = 1'b1;
        step_up = 1'b0;
      end
    end
  end

  // Compare against the limits before adding so WIDTH never overflows
  assign wrap_hit   = step_up ? (count_reg == MAX_VAL) : (count_reg == '0);
  assign step_value = step_up ? (wrap_hit ? '0 : count_reg + WIDTH'(1))
                              : (wrap_hit ? MAX_VAL : count_reg - WIDTH'(1));

  always_ff @(posedge global_clock or negedge reset) begin
    if (!reset) begin
      pending_reg    <= 4'b0000;
      count_reg      <= '0;
      presc_reg      <= '0;
      mode_reg       <= MANUAL;
      dir_reg        <= 1'b1;
      step_pulse_reg <= 1'b0;
      wrap_pulse_reg <= 1'b0;
    end else begin
      // A pulse landing on the edge its own bit is served re-arms the bit
      pending_reg    <= (pending_reg & ~served) |
                        {btn_clear, btn_mode, btn_up, btn_down};
      step_pulse_reg <= do_step;
      wrap_pulse_reg <= do_step & wrap_hit;

      if (served[3])    count_reg <= '0;
      else if (do_step) count_reg <= step_value;

      if (served[1])      dir_reg <= 1'b1;
      else if (served[0]) dir_reg <= 1'b0;

      if (served[2]) begin
        unique case (mode_reg)
          MANUAL:   mode_reg <= AUTO_RUN;
          AUTO_RUN: mode_reg <= AUTO_PAUSE;
          default:  mode_reg <= MANUAL;
        endcase
      end

      // Prescaler runs on the registered mode; entering AUTO_RUN restarts it
      if (served[3])                              presc_reg <= '0;
      else if (served[2] && mode_reg == MANUAL)   presc_reg <= '0;
      else if (mode_reg == AUTO_RUN)              presc_reg <= tick ? '0 : presc_reg + PW'(1);
    end
  end

  assign count_value = count_reg;
  assign mode_state  = mode_reg;
  assign count_dir   = dir_reg;
  assign step_pulse  = step_pulse_reg;
  assign wrap_pulse  = wrap_pulse_reg;
  assign busy        = |pending_reg;

endmodule

// File: tb/tb_counter_ctrl_sched.sv
module tb_counter_ctrl_sched;

  logic        global_clock;
  logic        reset;
  logic        btn_up;
  logic        btn_down;
  logic        btn_clear;
  logic        btn_mode;
  logic [15:0] count_value;
  logic [1:0]  mode_state;
  logic        count_dir;
  logic        step_pulse;
  logic        wrap_pulse;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  counter_ctrl_sched #(
    .WIDTH(16),
    .MAX_COUNT(9999),
    .TICK_DIV(4)
  ) dut (
    .global_clock(global_clock),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_clear(btn_clear),
    .btn_mode(btn_mode),
    .count_value(count_value),
    .mode_state(mode_state),
    .count_dir(count_dir),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse),
    .busy(busy)
  );

  initial global_clock = 1'b0;
  always #5 global_clock = ~global_clock;

  // Advance one rising edge and settle 1 ns past it
  task automatic step();
    @(posedge global_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Full output snapshot against expected values
  task automatic check_all(input string tag, input int cnt, input int md, input int dir,
                           input int stp, input int wrp, input int bsy);
    check({tag, ".count"}, 32'(count_value), 32'(cnt));
    check({tag, ".mode"},  32'(mode_state),  32'(md));
    check({tag, ".dir"},   32'(count_dir),   32'(dir));
    check({tag, ".step"},  32'(step_pulse),  32'(stp));
    check({tag, ".wrap"},  32'(wrap_pulse),  32'(wrp));
    check({tag, ".busy"},  32'(busy),        32'(bsy));
  endtask

  initial begin
    reset = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
    step(); step();
    check_all("reset", 0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    step();

    // Single up pulse: sampled at E0, served at E1
    btn_up = 1'b1; step(); btn_up = 1'b0;
    check_all("up_e0", 0, 0, 1, 0, 0, 1);
    step();
    check_all("up_e1", 1, 0, 1, 1, 0, 0);
    step();
    check("up_e2.step", 32'(step_pulse), 32'd0);

    // Bring count to 5
    for (int i = 0; i < 4; i++) begin
      btn_up = 1'b1; step(); btn_up = 1'b0; step();
    end
    check("count5", 32'(count_value), 32'd5);

    // Simultaneous up/down/clear: clear, up, down on consecutive edges
    btn_up = 1'b1; btn_down = 1'b1; btn_clear = 1'b1;
    step();
    btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0;
    check_all("multi_e0", 5, 0, 1, 0, 0, 1);
    step();
    check_all("multi_clear", 0, 0, 1, 0, 0, 1);
    step();
    check_all("multi_up", 1, 0, 1, 1, 0, 1);
    step();
    check_all("multi_down", 0, 0, 0, 1, 0, 0);

    // Wrap down from 0 then up from MAX
    btn_down = 1'b1; step(); btn_down = 1'b0; step();
    check_all("wrap_down", 9999, 0, 0, 1, 1, 0);
    btn_up = 1'b1; step(); btn_up = 1'b0; step();
    check_all("wrap_up", 0, 0, 1, 1, 1, 0);
    step();
    check_all("wrap_idle", 0, 0, 1, 0, 0, 0);

    // Enter AUTO_RUN (prescaler 0 after E1), ticks at E5, E9
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    check_all("run_e1", 0, 1, 1, 0, 0, 0);
    step(); step(); step();
    check_all("run_e4", 0, 1, 1, 0, 0, 0);
    step();
    check_all("run_tick1", 1, 1, 1, 1, 0, 0);
    step(); step(); step();
    check("run_e8.count", 32'(count_value), 32'd1);
    step();
    check_all("run_tick2", 2, 1, 1, 1, 0, 0);

    // Down in AUTO_RUN only flips direction; next tick at E13 decrements
    btn_down = 1'b1; step(); btn_down = 1'b0;
    step();
    check_all("run_dir", 2, 1, 0, 0, 0, 0);
    step();
    step();
    check_all("run_tick3", 1, 1, 0, 1, 0, 0);

    // AUTO_PAUSE freezes the count
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    check_all("pause", 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step();
    check_all("pause_hold", 1, 2, 0, 0, 0, 0);

    // PAUSE -> MANUAL -> AUTO_RUN, then clear lands on the tick edge F5
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    check("manual.mode", 32'(mode_state), 32'd0);
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    check("rerun.mode", 32'(mode_state), 32'd1);
    step(); step();
    btn_clear = 1'b1; step(); btn_clear = 1'b0;
    check_all("clr_f4", 1, 1, 0, 0, 0, 1);
    step();
    check_all("clr_tick", 0, 1, 0, 0, 0, 0);
    step(); step(); step();
    check_all("clr_f8", 0, 1, 0, 0, 0, 0);
    step();
    check_all("clr_next_tick", 9999, 1, 0, 1, 1, 0);

    // Back to MANUAL, clear, then count up to 37
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    btn_clear = 1'b1; step(); btn_clear = 1'b0; step();
    check("prep.mode", 32'(mode_state), 32'd0);
    check("prep.count", 32'(count_value), 32'd0);
    for (int i = 0; i < 37; i++) begin
      btn_up = 1'b1; step(); btn_up = 1'b0; step();
    end
    check_all("count37", 37, 0, 1, 1, 0, 0);

    // Queue up + mode, then reset mid-cycle before they are served
    btn_up = 1'b1; btn_mode = 1'b1; step();
    btn_up = 1'b0; btn_mode = 1'b0;
    check("queued.busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 1, 0, 0, 0);
    step();
    reset = 1'b1;
    step(); step(); step();
    check_all("post_reset", 0, 0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_ctrl_sched.md
Name: counter_ctrl_sched

Overview:
- Sequences the board counter from the debounced button pulses: up, down, clear and mode.
- Sits between the per-button debouncer instances and the display driver, and owns the count register.
- Queues simultaneous button events and serves them one per cycle by fixed priority.
- Adds an auto-run mode that steps the count from an internal prescaler tick.

Parameters:
- WIDTH, 16: width of count_value.
- MAX_COUNT, 9999: largest count value; the count wraps to 0 above it (4-digit decimal display).
- TICK_DIV, 100000000: global_clock cycles per auto-run step (1 s at 100 MHz). Must be >= 2.

Ports:
- global_clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_up  input  1  one-cycle debounced pulse.
- btn_down  input  1  one-cycle debounced pulse.
- btn_clear  input  1  one-cycle debounced pulse.
- btn_mode  input  1  one-cycle debounced pulse.
- count_value  output  WIDTH  current count, registered.
- mode_state  output  2  00 MANUAL, 01 AUTO_RUN, 10 AUTO_PAUSE; 11 is never driven.
- count_dir  output  1  1 = up, 0 = down.
- step_pulse  output  1  one cycle high on the edge that count_value stepped up or down (not on clear).
- wrap_pulse  output  1  one cycle high when that step wrapped.
- busy  output  1  high while any pending bit is set.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - count_value = 0, mode_state = MANUAL, count_dir = 1.
  - step_pulse = 0, wrap_pulse = 0, busy = 0.
  - Pending flags and prescaler = 0.
  - Reset asserted mid-operation discards all queued events.
- Pending flags: one sticky bit per button. Each edge: pending <= (pending & ~served) | {btn_clear, btn_mode, btn_up, btn_down}.
  - A pulse arriving on the edge its own bit is served re-sets that bit; it counts as a second event.
- Service: each edge serves at most one pending bit, taken from the registered pending vector.
  - Priority: clear > mode > up > down.
  - A pulse sampled at edge E0 is served no earlier than edge E1. Count updates at E1.
- Clear: count_value <= 0 and prescaler <= 0. mode_state and count_dir are unchanged. A tick coincident with clear is dropped.
- Mode: MANUAL -> AUTO_RUN -> AUTO_PAUSE -> MANUAL.
  - Entering AUTO_RUN zeroes the prescaler.
- Up/down in MANUAL: step the count by +1 or -1 and set count_dir accordingly. step_pulse = 1.
- Up/down in AUTO_RUN or AUTO_PAUSE: set count_dir = 1 or 0 only; no step.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in AUTO_RUN and holds in the other states.
  - At TICK_DIV-1 it wraps to 0 and generates a tick on that edge.
- Tick: steps the count using count_dir as registered before the edge.
  - A coincident up/down or mode service is also applied on the same edge.
  - A mode service leaving AUTO_RUN on the tick edge does not cancel the tick.
- Wrap-around:
  - Stepping up from MAX_COUNT gives 0.
  - Stepping down from 0 gives MAX_COUNT.
  - Both assert wrap_pulse with step_pulse.
- Arithmetic: count_value never exceeds MAX_COUNT. Compare before adding, with no overflow of WIDTH.
- Pulse outputs: step_pulse and wrap_pulse are registered and low on every edge without a step.
- busy: equals |pending (registered).

Test Plan:
- Reset, then single btn_up pulse in MANUAL -> count_value 0->1 two edges after the pulse; step_pulse for one cycle; busy high for one cycle.
- btn_up, btn_down and btn_clear pulsed on the same cycle with count = 5 -> served in the order clear, up, down on consecutive edges; count goes 0, 1, 0; busy drops after the third edge.
- MANUAL, count = 0, btn_down -> count = 9999 with step_pulse = 1, wrap_pulse = 1. Then btn_up -> count = 0 with wrap_pulse = 1.
- TICK_DIV = 4, btn_mode to AUTO_RUN, count_dir = 1 -> count steps every 4 cycles. btn_down -> later ticks decrement. btn_mode -> AUTO_PAUSE, count frozen and prescaler held.
- TICK_DIV = 4, AUTO_RUN, btn_clear landing on the tick edge -> count = 0, no step_pulse, next tick 4 cycles later.
- Reset asserted with pending up/mode bits and count = 37 -> all outputs immediately at reset values; no queued event applied after reset release.
